setpoint_encoder: RTL and testbench

- Operator-input front end for the servo tester.
- Turns a raw mechanical quadrature rotary encoder (A/B) and a push button into the 8-bit position setpoint that the PWM generator consumes on its setpoint input.
- Provides synchronisation, debouncing, quadrature decoding, saturating step arithmetic and a button-triggered centre preset.
- Sits directly upstream of the servo PWM stage.

---
 rtl/setpoint_encoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_setpoint_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/setpoint_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : setpoint_encoder
// Purpose  : Operator-input front end for the servo tester. Converts a raw
//            mechanical quadrature rotary encoder (A/B) and a push button
//            into the 8-bit position setpoint consumed by the PWM stage.
//            Provides synchronisation, debouncing, quadrature decoding,
//            saturating step arithmetic and a button-triggered centre
//            preset.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous assert, active-high reset
//            enc_a/enc_b  - raw encoder channels (asynchronous, bouncy)
//            enc_btn      - raw push button, 1 = pressed (asynchronous)
//            setpoint     - registered 8-bit setpoint
//            setpoint_upd - one-cycle pulse when setpoint takes a new value
//            quad_err     - one-cycle pulse on an illegal A/B transition
// Options  : define ENC_ACCEL_EN to enable detent acceleration (detents
//            closer than FAST_WINDOW clocks step by STEP_SIZE*ACCEL_MULT).
// Revision : 1.0 - initial release
// ============================================================================
module setpoint_encoder #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int STEP_SIZE       = 5,
   parameter int MAX_SETPOINT    = 255,
   parameter int RESET_VALUE     = 0,
   parameter int CENTER_VALUE    = 128,
   parameter int FAST_WINDOW     = 200000,
   parameter int ACCEL_MULT      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       enc_btn,
   output logic [7:0] setpoint,
   output logic       setpoint_upd,
   output logic       quad_err
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int BLK_W = $clog2(DEBOUNCE_CYCLES + 4);

   localparam logic [DEB_W-1:0] c_deb_last  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BLK_W-1:0] c_blank_ld  = BLK_W'(DEBOUNCE_CYCLES + 3);
   localparam logic [8:0]       c_step      = 9'(STEP_SIZE);
   localparam logic [8:0]       c_max       = 9'(MAX_SETPOINT);
   localparam logic [7:0]       c_reset_val = 8'(RESET_VALUE);
   localparam logic [7:0]       c_center    = 8'(CENTER_VALUE);

   // Elaboration-time sanity checks on the configuration.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("setpoint_encoder: DEBOUNCE_CYCLES must be >= 2");
   end
   if (FAST_WINDOW < 1 || ACCEL_MULT < 1) begin : g_bad_accel
      $error("setpoint_encoder: FAST_WINDOW and ACCEL_MULT must be >= 1");
   end

   // Bit order of the input vectors: [0]=A, [1]=B, [2]=button.
   logic [2:0]       sync1_q, sync1_d;
   logic [2:0]       sync2_q, sync2_d;
   logic [2:0]       deb;

   logic [BLK_W-1:0] blank_q, blank_d;
   logic [1:0]       prev_ab_q, prev_ab_d;
   logic             prev_btn_q, prev_btn_d;
   logic signed [3:0] sub_q, sub_d;
   logic [7:0]       setpoint_q, setpoint_d;
   logic             upd_q, upd_d;
   logic             quad_err_q, quad_err_d;

   logic             blanking;
   logic [1:0]       ab_cur;
   logic [1:0]       idx_cur, idx_prev, idx_cur_inc, idx_prev_inc;
   logic             step_cw, step_ccw, both_changed;
   logic             det_cw, det_ccw, press;
   logic [8:0]       step;
   logic [8:0]       sum;
   logic [7:0]       cw_val, ccw_val, new_val;

   // ------------------------------------------------------------------
   // Two-flop synchronisers
   // ------------------------------------------------------------------
   always_comb begin
      sync1_d = {enc_btn, enc_b, enc_a};
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // ------------------------------------------------------------------
   // Debouncers: the output follows the synced input only after it has
   // disagreed for DEBOUNCE_CYCLES consecutive clocks.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_q, cnt_d;
      logic             val_q, val_d;

      always_comb begin
         cnt_d = cnt_q;
         val_d = val_q;
         if (sync2_q[gi] == val_q) begin
            cnt_d = '0;
         end else if (cnt_q == c_deb_last) begin
            val_d = sync2_q[gi];
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
            val_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            val_q <= val_d;
         end
      end

      assign deb[gi] = val_q;
   end

   // ------------------------------------------------------------------
   // Step size (optionally accelerated)
   // ------------------------------------------------------------------
`ifdef ENC_ACCEL_EN
   localparam int TMR_W = $clog2(FAST_WINDOW + 1);
   localparam logic [TMR_W-1:0] c_fast      = TMR_W'(FAST_WINDOW);
   localparam logic [8:0]       c_step_fast = 9'(STEP_SIZE * ACCEL_MULT);

   logic [TMR_W-1:0] timer_q, timer_d;

   // Timer measures clocks since the previous detent; it starts saturated
   // so the first detent after reset is never accelerated.
   always_comb begin
      timer_d = timer_q;
      if (det_cw || det_ccw) begin
         timer_d = '0;
      end else if (timer_q < c_fast) begin
         timer_d = timer_q + 1'b1;
      end
      step = (timer_q < c_fast) ? c_step_fast : c_step;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q <= c_fast;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign step = c_step;
`endif

   // ------------------------------------------------------------------
   // Decoder, button edge detect and setpoint arithmetic
   // ------------------------------------------------------------------
   always_comb begin
      blanking   = (blank_q != '0);
      blank_d    = blanking ? (blank_q - 1'b1) : blank_q;

      ab_cur     = {deb[0], deb[1]};
      prev_ab_d  = ab_cur;
      prev_btn_d = deb[2];

      // Map Gray sequence 00,01,11,10 onto 0,1,2,3 so CW is "+1 mod 4".
      idx_cur      = {ab_cur[1], ab_cur[1] ^ ab_cur[0]};
      idx_prev     = {prev_ab_q[1], prev_ab_q[1] ^ prev_ab_q[0]};
      idx_cur_inc  = idx_cur + 2'd1;
      idx_prev_inc = idx_prev + 2'd1;
      step_cw      = (idx_cur == idx_prev_inc);
      step_ccw     = (idx_prev == idx_cur_inc);
      both_changed = ((ab_cur ^ prev_ab_q) == 2'b11);

      quad_err_d = !blanking && both_changed;

      sub_d   = sub_q;
      det_cw  = 1'b0;
      det_ccw = 1'b0;
      if (!blanking) begin
         if (step_cw) begin
            if (sub_q == 4'sd3) begin
               det_cw = 1'b1;
               sub_d  = 4'sd0;
            end else begin
               sub_d = sub_q + 4'sd1;
            end
         end else if (step_ccw) begin
            if (sub_q == -4'sd3) begin
               det_ccw = 1'b1;
               sub_d   = 4'sd0;
            end else begin
               sub_d = sub_q - 4'sd1;
            end
         end
      end

      press = !blanking && deb[2] && !prev_btn_q;

      sum     = {1'b0, setpoint_q} + step;
      cw_val  = (sum > c_max) ? c_max[7:0] : sum[7:0];
      // Clamp before subtracting so the result never wraps below zero.
      ccw_val = ({1'b0, setpoint_q} >= step) ? (setpoint_q - step[7:0]) : 8'd0;

      // A press takes priority over a detent in the same cycle.
      new_val = setpoint_q;
      if (press) begin
         new_val = c_center;
      end else if (det_cw) begin
         new_val = cw_val;
      end else if (det_ccw) begin
         new_val = ccw_val;
      end

      setpoint_d = new_val;
      upd_d      = (new_val != setpoint_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_q    <= c_blank_ld;
         prev_ab_q  <= 2'b00;
         prev_btn_q <= 1'b0;
         sub_q      <= 4'sd0;
         setpoint_q <= c_reset_val;
         upd_q      <= 1'b0;
         quad_err_q <= 1'b0;
      end else begin
         blank_q    <= blank_d;
         prev_ab_q  <= prev_ab_d;
         prev_btn_q <= prev_btn_d;
         sub_q      <= sub_d;
         setpoint_q <= setpoint_d;
         upd_q      <= upd_d;
         quad_err_q <= quad_err_d;
      end
   end

   assign setpoint     = setpoint_q;
   assign setpoint_upd = upd_q;
   assign quad_err     = quad_err_q;

endmodule
`default_nettype wire

// File: tb/tb_setpoint_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_setpoint_encoder
// Purpose  : Directed self-checking bench for setpoint_encoder
//            (DEBOUNCE_CYCLES=4, FAST_WINDOW=100, encoder phases held
//            10 clocks each).
// Revision : 1.0 - initial release
// ============================================================================
module tb_setpoint_encoder;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       enc_a   = 1'b0;
   logic       enc_b   = 1'b0;
   logic       enc_btn = 1'b0;
   logic [7:0] setpoint;
   logic       setpoint_upd;
   logic       quad_err;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int upd_cnt = 0;
   int err_cnt = 0;
   int upd_cyc = 0;
   int chg_cyc = 0;
   int upd_base, err_base;
   logic [1:0] cur_ab = 2'b00;

   setpoint_encoder #(
      .DEBOUNCE_CYCLES(4),
      .FAST_WINDOW    (100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enc_a       (enc_a),
      .enc_b       (enc_b),
      .enc_btn     (enc_btn),
      .setpoint    (setpoint),
      .setpoint_upd(setpoint_upd),
      .quad_err    (quad_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (setpoint_upd === 1'b1) begin
         upd_cnt <= upd_cnt + 1;
         upd_cyc <= cyc;
      end
      if (quad_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] cw_next(input logic [1:0] ab);
      case (ab)
         2'b00:   cw_next = 2'b01;
         2'b01:   cw_next = 2'b11;
         2'b11:   cw_next = 2'b10;
         default: cw_next = 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] ccw_next(input logic [1:0] ab);
      case (ab)
         2'b00:   ccw_next = 2'b10;
         2'b10:   ccw_next = 2'b11;
         2'b11:   ccw_next = 2'b01;
         default: ccw_next = 2'b00;
      endcase
   endfunction

   task automatic set_ab(input logic [1:0] ab);
      @(negedge clk);
      {enc_a, enc_b} = ab;
      cur_ab  = ab;
      chg_cyc = cyc;
      repeat (9) @(negedge clk);
   endtask

   task automatic detent_cw();
      repeat (4) set_ab(cw_next(cur_ab));
   endtask

   task automatic detent_ccw();
      repeat (4) set_ab(ccw_next(cur_ab));
   endtask

   task automatic do_reset(input logic [1:0] ab, input logic btn);
      @(negedge clk);
      reset = 1'b1;
      {enc_a, enc_b} = ab;
      cur_ab  = ab;
      enc_btn = btn;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic press_btn();
      @(negedge clk);
      enc_btn = 1'b1;
      repeat (10) @(negedge clk);
      enc_btn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic mark();
      upd_base = upd_cnt;
      err_base = err_cnt;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      // ---- Reset with everything idle ----
      repeat (2) @(negedge clk);
      check_eq("reset_setpoint", {24'd0, setpoint}, 32'd0);
      mark();
      reset = 1'b0;
      repeat (50) @(negedge clk);
      check_eq("idle_setpoint", {24'd0, setpoint}, 32'd0);
      check_eq("idle_upd", upd_cnt - upd_base, 32'd0);
      check_eq("idle_err", err_cnt - err_base, 32'd0);

      // ---- Reset resting at AB=11, then one CW detent ----
      do_reset(2'b11, 1'b0);
      mark();
      detent_cw();
      repeat (10) @(negedge clk);
      check_eq("ab11_err", err_cnt - err_base, 32'd0);
      check_eq("ab11_upd", upd_cnt - upd_base, 32'd1);
      check_eq("ab11_setpoint", {24'd0, setpoint}, 32'd5);
      check_eq("ab11_latency", upd_cyc - chg_cyc, 32'd7);

`ifdef ENC_ACCEL_EN
      // ---- Acceleration ----
      do_reset(2'b00, 1'b0);
      detent_cw();
      check_eq("acc_first", {24'd0, setpoint}, 32'd5);
      repeat (20) @(negedge clk);
      detent_cw();
      check_eq("acc_fast", {24'd0, setpoint}, 32'd25);
      repeat (110) @(negedge clk);
      detent_cw();
      check_eq("acc_slow", {24'd0, setpoint}, 32'd30);
`else
      // ---- Lower and upper saturation ----
      do_reset(2'b00, 1'b0);
      mark();
      detent_ccw();
      check_eq("ccw_at0_setpoint", {24'd0, setpoint}, 32'd0);
      check_eq("ccw_at0_upd", upd_cnt - upd_base, 32'd0);
      for (int i = 0; i < 50; i++) detent_cw();
      check_eq("cw50_setpoint", {24'd0, setpoint}, 32'd250);
      detent_cw();
      check_eq("cw51_setpoint", {24'd0, setpoint}, 32'd255);
      check_eq("cw51_upd", upd_cnt - upd_base, 32'd51);
      mark();
      detent_cw();
      check_eq("cw52_setpoint", {24'd0, setpoint}, 32'd255);
      check_eq("cw52_upd", upd_cnt - upd_base, 32'd0);

      // ---- Glitch rejection and illegal transition at 40 ----
      do_reset(2'b00, 1'b0);
      for (int i = 0; i < 8; i++) detent_cw();
      check_eq("to40_setpoint", {24'd0, setpoint}, 32'd40);
      mark();
      @(negedge clk);
      enc_a = 1'b1;
      repeat (3) @(negedge clk);
      enc_a = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("glitch_setpoint", {24'd0, setpoint}, 32'd40);
      check_eq("glitch_upd", upd_cnt - upd_base, 32'd0);
      check_eq("glitch_err", err_cnt - err_base, 32'd0);
      @(negedge clk);
      {enc_a, enc_b} = 2'b11;
      cur_ab = 2'b11;
      repeat (20) @(negedge clk);
      check_eq("qerr_count", err_cnt - err_base, 32'd1);
      check_eq("qerr_setpoint", {24'd0, setpoint}, 32'd40);
      check_eq("qerr_upd", upd_cnt - upd_base, 32'd0);

      // ---- Button centre preset ----
      mark();
      press_btn();
      check_eq("press_setpoint", {24'd0, setpoint}, 32'd128);
      check_eq("press_upd", upd_cnt - upd_base, 32'd1);
      mark();
      press_btn();
      check_eq("press2_setpoint", {24'd0, setpoint}, 32'd128);
      check_eq("press2_upd", upd_cnt - upd_base, 32'd0);

      // Press arriving together with the 4th transition of a detent.
      mark();
      repeat (3) set_ab(cw_next(cur_ab));
      @(negedge clk);
      {enc_a, enc_b} = cw_next(cur_ab);
      cur_ab  = cw_next(cur_ab);
      enc_btn = 1'b1;
      repeat (10) @(negedge clk);
      enc_btn = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("press_detent_setpoint", {24'd0, setpoint}, 32'd128);
      check_eq("press_detent_upd", upd_cnt - upd_base, 32'd0);
      check_eq("press_detent_err", err_cnt - err_base, 32'd0);
      // The discarded detent must not leave a partial count behind.
      detent_cw();
      check_eq("after_press_setpoint", {24'd0, setpoint}, 32'd133);
      check_eq("after_press_upd", upd_cnt - upd_base, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
